// File: rtl/krnl_vadd_rtl_axi_read_issuer.sv
`default_nettype none
// ============================================================================
// Module      : krnl_vadd_rtl_axi_read_issuer
// Description : AXI4 read-address issuer. Splits a byte range into AR bursts
//               and tracks in-flight bursts with an up/down credit counter.
// Revision    : 1.0 - initial release
// ============================================================================
module krnl_vadd_rtl_axi_read_issuer #(
    parameter int C_ADDR_WIDTH      = 64,
    parameter int C_DATA_WIDTH      = 512,
    parameter int C_SIZE_WIDTH      = 32,
    parameter int C_BURST_LEN       = 16,
    parameter int C_MAX_OUTSTANDING = 16
) (
    input  logic                                ap_clk,
    input  logic                                ap_rst_n,
    input  logic                                ctrl_start,
    input  logic [C_ADDR_WIDTH-1:0]             ctrl_offset,
    input  logic [C_SIZE_WIDTH-1:0]             ctrl_size,
    output logic                                ctrl_done,
    output logic                                ctrl_busy,
    output logic                                m_arvalid,
    input  logic                                m_arready,
    output logic [C_ADDR_WIDTH-1:0]             m_araddr,
    output logic [7:0]                          m_arlen,
    input  logic                                burst_done,
    output logic [$clog2(C_MAX_OUTSTANDING):0]  outstanding
);
    localparam int C_BPB     = C_DATA_WIDTH / 8;
    localparam int C_LOG_BPB = $clog2(C_BPB);
    localparam int C_LOG_BL  = $clog2(C_BURST_LEN);
    localparam int C_CNT_W   = $clog2(C_MAX_OUTSTANDING) + 1;
    localparam int C_CALC_W  = C_SIZE_WIDTH + 1;

    localparam logic [C_CNT_W-1:0]      C_MAX_CNT    = C_CNT_W'(C_MAX_OUTSTANDING);
    localparam logic [C_CNT_W-1:0]      C_CNT_ONE    = C_CNT_W'(1);
    localparam logic [C_ADDR_WIDTH-1:0] C_ADDR_STEP  = C_ADDR_WIDTH'(C_BURST_LEN * C_BPB);
    localparam logic [C_ADDR_WIDTH-1:0] C_ALIGN_MASK = ~C_ADDR_WIDTH'(C_BPB - 1);
    localparam logic [C_CALC_W-1:0]     C_BPB_M1     = C_CALC_W'(C_BPB - 1);
    localparam logic [C_CALC_W-1:0]     C_BL_M1      = C_CALC_W'(C_BURST_LEN - 1);
    localparam logic [C_CALC_W-1:0]     C_CALC_ONE   = C_CALC_W'(1);
    localparam logic [7:0]              C_FULL_ARLEN = 8'(C_BURST_LEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CALC  = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]              r_state;
    logic [2:0]              w_state_next;
    logic [C_SIZE_WIDTH-1:0] r_size;
    logic [C_ADDR_WIDTH-1:0] r_addr;
    logic [C_CALC_W-1:0]     r_bursts_left;
    logic [7:0]              r_last_arlen;
    logic [C_CNT_W-1:0]      r_outstanding;
    logic [C_CALC_W-1:0]     w_beats;
    logic [C_CALC_W-1:0]     w_bursts;
    logic [7:0]              w_last_arlen;
    logic                    w_ar_hs;
    logic                    w_credit_ret;

    // Extra MSB keeps the round-up additions from overflowing.
    assign w_beats      = ({1'b0, r_size} + C_BPB_M1) >> C_LOG_BPB;
    assign w_bursts     = (w_beats + C_BL_M1) >> C_LOG_BL;
    // (last length - 1) equals (beats - 1) modulo the burst length.
    assign w_last_arlen = (w_beats[7:0] - 8'd1) & C_FULL_ARLEN;

    assign w_ar_hs      = m_arvalid && m_arready;
    assign w_credit_ret = burst_done && (r_outstanding != '0);
    assign m_araddr     = r_addr;
    assign outstanding  = r_outstanding;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (ctrl_start) w_state_next = S_CALC;
            S_CALC:  w_state_next = (w_bursts != '0) ? S_ISSUE : S_DONE;
            S_ISSUE: if (w_ar_hs && (r_bursts_left == C_CALC_ONE)) w_state_next = S_DRAIN;
            S_DRAIN: if (r_outstanding == '0) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // arvalid depends only on registered state, so it cannot drop before arready.
    always_comb begin
        ctrl_done = (r_state == S_DONE);
        ctrl_busy = (r_state != S_IDLE);
        m_arvalid = (r_state == S_ISSUE) && (r_outstanding < C_MAX_CNT);
        m_arlen   = 8'd0;
        if (r_state == S_ISSUE) begin
            m_arlen = (r_bursts_left == C_CALC_ONE) ? r_last_arlen : C_FULL_ARLEN;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_size        <= '0;
            r_addr        <= '0;
            r_bursts_left <= '0;
            r_last_arlen  <= '0;
        end else begin
            if ((r_state == S_IDLE) && ctrl_start) begin
                r_size <= ctrl_size;
                r_addr <= ctrl_offset & C_ALIGN_MASK;
            end
            if (r_state == S_CALC) begin
                r_bursts_left <= w_bursts;
                r_last_arlen  <= w_last_arlen;
            end
            if (w_ar_hs) begin
                r_addr        <= r_addr + C_ADDR_STEP;
                r_bursts_left <= r_bursts_left - C_CALC_ONE;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_outstanding <= '0;
        end else begin
            case ({w_ar_hs, w_credit_ret})
                2'b10:   r_outstanding <= r_outstanding + C_CNT_ONE;
                2'b01:   r_outstanding <= r_outstanding - C_CNT_ONE;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    a_no_underflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
        !(burst_done && (r_outstanding == '0)));

endmodule
`default_nettype wire

// File: tb/tb_krnl_vadd_rtl_axi_read_issuer.sv
`default_nettype none
// ============================================================================
// Module      : tb_krnl_vadd_rtl_axi_read_issuer
// Description : Directed self-checking bench for the AXI read-address issuer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_krnl_vadd_rtl_axi_read_issuer;
    logic        ap_clk;
    logic        ap_rst_n;
    logic        ctrl_start;
    logic [63:0] ctrl_offset;
    logic [31:0] ctrl_size;
    logic        ctrl_done;
    logic        ctrl_busy;
    logic        m_arvalid;
    logic        m_arready;
    logic [63:0] m_araddr;
    logic [7:0]  m_arlen;
    logic        burst_done;
    logic [2:0]  outstanding;

    int          n_vec;
    int          n_err;
    int          n_cyc;
    logic        auto_bd;
    logic [7:0]  bd_pipe;
    logic [63:0] q_addr[$];
    logic [7:0]  q_len[$];
    logic [63:0] hold_addr;

    krnl_vadd_rtl_axi_read_issuer #(
        .C_ADDR_WIDTH      (64),
        .C_DATA_WIDTH      (512),
        .C_SIZE_WIDTH      (32),
        .C_BURST_LEN       (16),
        .C_MAX_OUTSTANDING (4)
    ) dut (
        .ap_clk      (ap_clk),
        .ap_rst_n    (ap_rst_n),
        .ctrl_start  (ctrl_start),
        .ctrl_offset (ctrl_offset),
        .ctrl_size   (ctrl_size),
        .ctrl_done   (ctrl_done),
        .ctrl_busy   (ctrl_busy),
        .m_arvalid   (m_arvalid),
        .m_arready   (m_arready),
        .m_araddr    (m_araddr),
        .m_arlen     (m_arlen),
        .burst_done  (burst_done),
        .outstanding (outstanding)
    );

    initial ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Logs this cycle's AR handshake, then advances one clock; burst_done
    // fires 3 cycles after each handshake when auto_bd is set.
    task automatic tick();
        #1;
        if (m_arvalid && m_arready) begin
            q_addr.push_back(m_araddr);
            q_len.push_back(m_arlen);
            if (auto_bd) bd_pipe[3] = 1'b1;
        end
        @(posedge ap_clk);
        #1;
        bd_pipe    = bd_pipe >> 1;
        burst_done = bd_pipe[0];
    endtask

    task automatic start(input logic [63:0] off, input logic [31:0] sz);
        ctrl_offset = off;
        ctrl_size   = sz;
        ctrl_start  = 1'b1;
        tick();
        ctrl_start  = 1'b0;
    endtask

    task automatic run_until_done(input string tag, output int n);
        n = 0;
        while (!ctrl_done && n < 200) begin
            tick();
            n++;
        end
        chk(tag, {63'd0, ctrl_done}, 64'd1);
    endtask

    task automatic clear_log();
        q_addr.delete();
        q_len.delete();
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        ap_rst_n = 1'b0; ctrl_start = 1'b0; ctrl_offset = '0; ctrl_size = '0;
        m_arready = 1'b0; burst_done = 1'b0; auto_bd = 1'b0; bd_pipe = '0;

        // Reset values
        #12;
        chk("rst_ctl", {61'd0, m_arvalid, ctrl_done, ctrl_busy}, 64'd0);
        chk("rst_out", {61'd0, outstanding}, 64'd0);
        chk("rst_addr", m_araddr, 64'd0);
        chk("rst_len", {56'd0, m_arlen}, 64'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1;
        tick();

        // 1: 4 KB from 0x1000, always ready, completions 3 cycles after AR
        clear_log(); auto_bd = 1'b1; m_arready = 1'b1;
        start(64'h1000, 32'd4096);
        chk("t1_busy", {63'd0, ctrl_busy}, 64'd1);
        run_until_done("t1_done", n_cyc);
        chk("t1_lat", n_cyc, 64'd9);
        chk("t1_nar", q_addr.size(), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_addr%0d", i), q_addr[i], 64'h1000 + 64'(i) * 64'h400);
            chk($sformatf("t1_len%0d", i), {56'd0, q_len[i]}, 64'd15);
        end
        chk("t1_out", {61'd0, outstanding}, 64'd0);
        tick();
        chk("t1_idle", {62'd0, ctrl_done, ctrl_busy}, 64'd0);

        // 2: short transfer and one-beat tail with unaligned offset low bits
        clear_log();
        start(64'h2000, 32'd100);
        run_until_done("t2a_done", n_cyc);
        chk("t2a_lat", n_cyc, 64'd6);
        chk("t2a_nar", q_addr.size(), 64'd1);
        chk("t2a_addr", q_addr[0], 64'h2000);
        chk("t2a_len", {56'd0, q_len[0]}, 64'd1);
        tick();
        clear_log();
        start(64'h3020, 32'd1088);
        run_until_done("t2b_done", n_cyc);
        chk("t2b_lat", n_cyc, 64'd7);
        chk("t2b_nar", q_addr.size(), 64'd2);
        chk("t2b_addr0", q_addr[0], 64'h3000);
        chk("t2b_addr1", q_addr[1], 64'h3400);
        chk("t2b_len0", {56'd0, q_len[0]}, 64'd15);
        chk("t2b_len1", {56'd0, q_len[1]}, 64'd0);
        tick();

        // 3: zero size, done two cycles after start, no AR
        clear_log();
        start(64'h4000, 32'd0);
        chk("t3_c1", {61'd0, ctrl_done, ctrl_busy, m_arvalid}, 64'b010);
        tick();
        chk("t3_c2", {61'd0, ctrl_done, ctrl_busy, m_arvalid}, 64'b110);
        tick();
        chk("t3_c3", {61'd0, ctrl_done, ctrl_busy, m_arvalid}, 64'b000);
        chk("t3_nar", q_addr.size(), 64'd0);

        // 4: credit limit of 4 with no completions
        clear_log(); auto_bd = 1'b0;
        start(64'h20000, 32'd8192);
        for (int i = 0; i < 12; i++) tick();
        chk("t4_nar4", q_addr.size(), 64'd4);
        chk("t4_out4", {61'd0, outstanding}, 64'd4);
        chk("t4_vld0", {63'd0, m_arvalid}, 64'd0);
        burst_done = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) tick();
        chk("t4_nar5", q_addr.size(), 64'd5);
        chk("t4_out5", {61'd0, outstanding}, 64'd4);
        chk("t4_vld1", {63'd0, m_arvalid}, 64'd0);
        chk("t4_addr4", q_addr[4], 64'h21000);
        for (int i = 0; i < 7; i++) begin
            burst_done = 1'b1;
            tick();
            tick();
        end
        run_until_done("t4_done", n_cyc);
        chk("t4_nar8", q_addr.size(), 64'd8);
        chk("t4_addr7", q_addr[7], 64'h21C00);
        chk("t4_len7", {56'd0, q_len[7]}, 64'd15);
        tick();

        // 5: stall on arready, ignored restart, coincident AR + completion
        clear_log(); m_arready = 1'b0;
        start(64'h8000, 32'd2048);
        tick();
        for (int i = 0; i < 10; i++) begin
            chk("t5_hold_addr", m_araddr, 64'h8000);
            chk("t5_hold_vl", {55'd0, m_arvalid, m_arlen}, {55'd0, 1'b1, 8'd15});
            if (i == 3) begin
                ctrl_offset = 64'h9000;
                ctrl_start  = 1'b1;
            end
            tick();
            ctrl_start = 1'b0;
        end
        m_arready = 1'b1;
        tick();
        m_arready = 1'b0;
        hold_addr = m_araddr;
        chk("t5_addr1", hold_addr, 64'h8400);
        chk("t5_out1", {61'd0, outstanding}, 64'd1);
        m_arready = 1'b1; burst_done = 1'b1;
        tick();
        m_arready = 1'b0;
        chk("t5_out_coinc", {61'd0, outstanding}, 64'd1);
        chk("t5_drain_vld", {63'd0, m_arvalid}, 64'd0);
        burst_done = 1'b1;
        tick();
        run_until_done("t5_done", n_cyc);
        chk("t5_nar", q_addr.size(), 64'd2);
        tick();

        // 6: asynchronous reset while issuing, then clean restart
        clear_log(); m_arready = 1'b1;
        start(64'h0, 32'd8192);
        tick(); tick(); tick(); tick();
        chk("t6_pre_out", {61'd0, outstanding}, 64'd3);
        #2;
        ap_rst_n = 1'b0;
        #1;
        chk("t6_rst_ctl", {61'd0, m_arvalid, ctrl_busy, ctrl_done}, 64'd0);
        chk("t6_rst_out", {61'd0, outstanding}, 64'd0);
        chk("t6_rst_addr", m_araddr, 64'd0);
        @(posedge ap_clk); #1;
        ap_rst_n = 1'b1; bd_pipe = '0; burst_done = 1'b0;
        tick();
        clear_log(); auto_bd = 1'b1;
        start(64'h10000, 32'd2048);
        run_until_done("t6_done", n_cyc);
        chk("t6_nar", q_addr.size(), 64'd2);
        chk("t6_addr0", q_addr[0], 64'h10000);
        chk("t6_addr1", q_addr[1], 64'h10400);
        chk("t6_lens", {48'd0, q_len[0], q_len[1]}, {48'd0, 8'd15, 8'd15});
        tick();
        chk("t6_idle", {61'd0, ctrl_busy, outstanding == 3'd0, ctrl_done}, 64'b010);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
